seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Round-robin scheduler that shares one bit-serial sequence detector between `N_REQ` requesters. It accepts one `FRAME_LEN`-bit frame at a time and flushes the detector with its synchronous reset. It then shifts the frame in MSB-first, counts the detector's hit pulses, and reports the count and requester ID on a valid/ready result port. It sits between the frame producers and the single detector instance, and is the only driver of the detector's `rst` and `i` inputs.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `FRAME_LEN`, 16, bits per frame (2..64)
- `CNT_W`, 6, hit-count width; the count saturates at 2^CNT_W-1
- `clk` in 1: single clock; everything updates on posedge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in N_REQ: requester k has a frame pending
- `req_data` in N_REQ*FRAME_LEN: frame of requester k at `[k*FRAME_LEN +: FRAME_LEN]`
- `req_ready` out N_REQ: one-hot accept; a transfer occurs when `req_valid[k] & req_ready[k]`
- `det_rst` out 1: synchronous reset to the detector
- `det_i` out 1: serial bit to the detector
- `det_out` in 1: detector hit flag, registered in the detector (reflects the `det_i` of the previous cycle)
- `done_valid` out 1: result available
- `done_ready` in 1: consumer accepts the result
- `done_id` out $clog2(N_REQ): requester whose frame produced the result
- `done_hits` out CNT_W: number of hit pulses
- `busy` out 1: the state is not IDLE

## Operation
- States: IDLE, FLUSH, FEED, DRAIN, REPORT.
- IDLE
  - If any `req_valid` is set, select the first valid requester at or after `rr_ptr`, wrapping modulo N_REQ.
  - Assert `req_ready[sel]` combinationally in this cycle only.
  - Latch `req_data` into the shift register and `sel` into `cur_id`.
  - Set `rr_ptr` to (sel+1) mod N_REQ, clear `hit_cnt`, and go to FLUSH.
  - If no request is pending, stay in IDLE.
- FLUSH
  - One cycle with `det_rst`=1 and `det_i`=0, then go to FEED with `bit_idx`=0.
- FEED
  - `det_i` = shift[FRAME_LEN-1]; shift left each cycle; lasts exactly FRAME_LEN cycles.
  - `det_out` is sampled in every FEED cycle except the one with `bit_idx`=0, which reflects the FLUSH cycle.
  - After `bit_idx`=FRAME_LEN-1, go to DRAIN.
- DRAIN
  - One cycle with `det_i`=0 and `det_rst`=0.
  - Sample `det_out` (the hit for the last bit), then go to REPORT.
- Hit counting: `hit_cnt` increments on each sampled `det_out`=1 and saturates at all-ones; it never wraps.
- REPORT
  - `done_valid`=1, `done_id`=`cur_id`, `done_hits`=`hit_cnt`, held stable until `done_ready`.
  - On `done_valid & done_ready`, go to IDLE. No new request is accepted in the same cycle.
- `det_rst` is 0 in every state except FLUSH and reset.
- `req_ready` is all-zero outside IDLE.
- Requesters must hold `req_valid`/`req_data` stable until their handshake. Deasserting early is legal and simply drops them from arbitration.

## Timing
- Reset values
  - state=IDLE, `rr_ptr`=0, shift=0, `hit_cnt`=0.
  - `req_ready`=0, `det_rst`=1 (the detector is also held in reset while `rst` is high).
  - `det_i`=0, `done_valid`=0, `done_id`=0, `done_hits`=0, `busy`=0.
- Handshake at cycle A gives:
  - FLUSH at A+1
  - FEED at A+2..A+1+FRAME_LEN
  - DRAIN at A+2+FRAME_LEN
  - `done_valid` first high at A+3+FRAME_LEN
- Minimum handshake-to-handshake spacing is FRAME_LEN+4 cycles (zero-wait `done_ready`).
- `rst` asserted mid-frame or in REPORT
  - Next cycle: IDLE with all reset values.
  - The in-flight frame and its result are discarded.
  - `rr_ptr` returns to 0.
- Simultaneous requests: exactly one is granted per IDLE visit. A requester left waiting is served within N_REQ-1 further frames.

## Structure
- Package `seq_det_pkg`
  - `sched_state_e` enum
  - default constants `SEQ_FRAME_LEN`, `SEQ_CNT_W`
  - the `sat_inc` function
- Sub-module `rr_arbiter`
  - parameter N
  - inputs: `req[N]`, `ptr`
  - outputs: one-hot `gnt`, binary `gnt_id`, `any`
  - purely combinational rotate-priority logic
- Everything else lives in `seq_det_scheduler`.

## Test plan
Benches use a detector stub whose `det_out` is `det_i` registered one cycle, cleared on `det_rst`, so hits = popcount(frame).
- Single request: N_REQ=4, `req_valid`=0010, frame 16'hA5F0 → `req_ready`=0010 for one cycle; `done_valid` 19 cycles later with `done_id`=1 and `done_hits`=8; `det_rst` high exactly one cycle.
- All four valid continuously with `done_ready`=1 → grant order 0,1,2,3,0, each handshake 20 cycles apart.
- Requester 2 only, then 0 and 3 together → grant 2, then 3 (pointer=3), then 0.
- `done_ready` held low for 7 cycles in REPORT → `done_valid`/`done_id`/`done_hits` stable throughout, no `req_ready`; IDLE the cycle after acceptance.
- `rst` pulsed at FEED `bit_idx`=5 → next cycle all outputs at reset values, no `done_valid`; the following grant goes to requester 0 first.
- CNT_W=3, frame 16'hFFFF → `done_hits`=7 (saturated), not 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sequence-detector scheduler.
// Holds the FSM state enum, default sizes and a saturating increment.
package seq_det_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } sched_state_e;

    localparam int SEQ_FRAME_LEN = 16;
    localparam int SEQ_CNT_W     = 6;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_v) ? max_v : value + 64'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first request at or
// after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    // Walk offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        int j;
        gnt_id = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                gnt_id = ID_W'(j);
                any    = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign gnt[gi] = any && (gnt_id == ID_W'(gi));
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one bit-serial sequence detector: flush,
// feed a frame MSB-first, count hits, report count and requester ID.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int FRAME_LEN = SEQ_FRAME_LEN,
    parameter  int CNT_W     = SEQ_CNT_W,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*FRAME_LEN-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       det_rst,
    output logic                       det_i,
    input  logic                       det_out,
    output logic                       done_valid,
    input  logic                       done_ready,
    output logic [ID_W-1:0]            done_id,
    output logic [CNT_W-1:0]           done_hits,
    output logic                       busy
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    sched_state_e         state_reg;
    logic [ID_W-1:0]      rr_ptr_reg;
    logic [ID_W-1:0]      cur_id_reg;
    logic [FRAME_LEN-1:0] shift_reg;
    logic [CNT_W-1:0]     hit_cnt_reg;
    logic [CNT_W-1:0]     hit_cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic                 det_rst_reg;
    logic                 det_i_reg;
    logic                 done_valid_reg;
    logic [ID_W-1:0]      done_id_reg;
    logic [CNT_W-1:0]     done_hits_reg;

    logic [N_REQ-1:0]     arb_req;
    logic [N_REQ-1:0]     arb_gnt;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_any;

    assign arb_req = (state_reg == S_IDLE) ? req_valid : '0;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (arb_req),
        .ptr    (rr_ptr_reg),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // The FEED cycle with bit_idx 0 still shows the flushed detector, so skip it.
    always_comb begin
        hit_cnt_next = hit_cnt_reg;
        if (det_out && (((state_reg == S_FEED) && (bit_idx_reg != '0)) || (state_reg == S_DRAIN))) begin
            hit_cnt_next = CNT_W'(sat_inc(64'(hit_cnt_reg), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            rr_ptr_reg     <= '0;
            cur_id_reg     <= '0;
            shift_reg      <= '0;
            hit_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            det_rst_reg    <= 1'b1;
            det_i_reg      <= 1'b0;
            done_valid_reg <= 1'b0;
            done_id_reg    <= '0;
            done_hits_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    det_rst_reg <= 1'b0;
                    if (arb_any) begin
                        shift_reg   <= req_data[int'(arb_id)*FRAME_LEN +: FRAME_LEN];
                        cur_id_reg  <= arb_id;
                        rr_ptr_reg  <= (arb_id == LAST_ID) ? '0 : arb_id + ID_W'(1);
                        hit_cnt_reg <= '0;
                        det_rst_reg <= 1'b1;
                        state_reg   <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    det_rst_reg <= 1'b0;
                    det_i_reg   <= shift_reg[FRAME_LEN-1];
                    shift_reg   <= shift_reg << 1;
                    bit_idx_reg <= '0;
                    state_reg   <= S_FEED;
                end
                S_FEED: begin
                    hit_cnt_reg <= hit_cnt_next;
                    if (bit_idx_reg == LAST_IDX) begin
                        det_i_reg <= 1'b0;
                        state_reg <= S_DRAIN;
                    end else begin
                        det_i_reg   <= shift_reg[FRAME_LEN-1];
                        shift_reg   <= shift_reg << 1;
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    hit_cnt_reg    <= hit_cnt_next;
                    done_hits_reg  <= hit_cnt_next;
                    done_id_reg    <= cur_id_reg;
                    done_valid_reg <= 1'b1;
                    state_reg      <= S_REPORT;
                end
                S_REPORT: begin
                    if (done_ready) begin
                        done_valid_reg <= 1'b0;
                        state_reg      <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = arb_gnt;
    assign det_rst    = det_rst_reg;
    assign det_i      = det_i_reg;
    assign done_valid = done_valid_reg;
    assign done_id    = done_id_reg;
    assign done_hits  = done_hits_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench: two schedulers (6-bit and 3-bit hit counters) with stub
// detectors, checked every cycle against a timeline model of each frame.
module tb_seq_det_scheduler;

    localparam int N  = 4;
    localparam int FL = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*FL-1:0] req_data = '0;
    logic            done_ready = 1'b1;

    logic [N-1:0] req_ready, s_req_ready;
    logic         det_rst, det_i, det_out, s_det_rst, s_det_i, s_det_out;
    logic         done_valid, s_done_valid, busy, s_busy;
    logic [1:0]   done_id, s_done_id;
    logic [5:0]   done_hits;
    logic [2:0]   s_done_hits;

    always #5 clk = ~clk;

    seq_det_scheduler #(.N_REQ(N), .FRAME_LEN(FL), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .det_rst(det_rst), .det_i(det_i), .det_out(det_out),
        .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
        .done_hits(done_hits), .busy(busy)
    );

    seq_det_scheduler #(.N_REQ(N), .FRAME_LEN(FL), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(s_req_ready), .det_rst(s_det_rst), .det_i(s_det_i), .det_out(s_det_out),
        .done_valid(s_done_valid), .done_ready(done_ready), .done_id(s_done_id),
        .done_hits(s_done_hits), .busy(s_busy)
    );

    // Detector stubs: det_i registered, cleared by det_rst.
    always @(posedge clk) begin
        det_out   <= det_rst ? 1'b0 : det_i;
        s_det_out <= s_det_rst ? 1'b0 : s_det_i;
    end

    typedef struct {int id; int cyc;} gnt_t;
    typedef struct {int id; int hits; int shits; int lat; int held;} res_t;

    int     vectors = 0;
    int     fails   = 0;
    int     cyc     = 0;
    gnt_t   gq[$];
    res_t   rq[$];
    logic [N-1:0] hs_last = '0;
    int     dr_cnt = 0;
    int     dv_run = 0;
    int     last_g_cyc = 0;
    bit     sticky = 1'b0;

    // Model state: one frame timeline keyed on its handshake cycle.
    bit           m_known = 1'b0;
    bit           m_rst_last = 1'b0;
    bit           m_act = 1'b0;
    int           m_t0 = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    logic [FL-1:0] m_frame = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic int exp_hits(input logic [FL-1:0] f, input int w);
        int pc;
        int mx;
        pc = $countones(f);
        mx = (1 << w) - 1;
        return (pc > mx) ? mx : pc;
    endfunction

    always @(negedge clk) begin : p_cmp
        logic [N-1:0] e_ready;
        logic e_busy, e_drst, e_di, e_dv;
        int k, g, j;
        g = -1;
        e_ready = '0;
        e_busy = 1'b0; e_drst = 1'b0; e_di = 1'b0; e_dv = 1'b0;
        if (!m_act) begin
            for (int off = 0; off < N; off++) begin
                j = (m_ptr + off) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            if (g >= 0) e_ready[g] = 1'b1;
            e_drst = m_rst_last;
        end else begin
            k = cyc - m_t0;
            e_busy = 1'b1;
            e_drst = (k == 1);
            e_di = (k >= 2 && k <= FL + 1) ? m_frame[FL-1-(k-2)] : 1'b0;
            e_dv = (k >= FL + 3);
        end
        if (m_known) begin
            chk("req_ready", req_ready, e_ready);
            chk("s_req_ready", s_req_ready, e_ready);
            chk("det_rst", det_rst, e_drst);
            chk("s_det_rst", s_det_rst, e_drst);
            chk("det_i", det_i, e_di);
            chk("s_det_i", s_det_i, e_di);
            chk("busy", busy, e_busy);
            chk("s_busy", s_busy, e_busy);
            chk("done_valid", done_valid, e_dv);
            chk("s_done_valid", s_done_valid, e_dv);
            if (e_dv) begin
                chk("done_id", done_id, m_id);
                chk("s_done_id", s_done_id, m_id);
                chk("done_hits", done_hits, exp_hits(m_frame, 6));
                chk("s_done_hits", s_done_hits, exp_hits(m_frame, 3));
            end
            if (m_rst_last) begin
                chk("rst_done_id", done_id, 0);
                chk("rst_done_hits", done_hits, 0);
                chk("rst_s_done_hits", s_done_hits, 0);
            end
        end
        // Observations of the main DUT for the literal checks.
        hs_last = req_valid & req_ready;
        if (hs_last != '0) begin
            for (int i = 0; i < N; i++) if (hs_last[i]) gq.push_back('{id: i, cyc: cyc});
            last_g_cyc = cyc;
        end
        if (det_rst) dr_cnt++;
        if (done_valid) begin
            if (done_ready) begin
                rq.push_back('{id: int'(done_id), hits: int'(done_hits), shits: int'(s_done_hits),
                               lat: cyc - last_g_cyc, held: dv_run});
                $display("result id=%0d hits=%0d sat_hits=%0d latency=%0d held=%0d",
                         done_id, done_hits, s_done_hits, cyc - last_g_cyc, dv_run);
                dv_run = 0;
            end else begin
                dv_run++;
            end
        end
        if (rst) begin
            m_act = 1'b0; m_ptr = 0; m_rst_last = 1'b1; m_known = 1'b1;
        end else begin
            m_rst_last = 1'b0;
            if (!m_act) begin
                if (g >= 0) begin
                    m_act = 1'b1; m_t0 = cyc; m_id = g;
                    m_frame = req_data[g*FL +: FL];
                    m_ptr = (g + 1) % N;
                end
            end else if (e_dv && done_ready) begin
                m_act = 1'b0;
            end
        end
        cyc++;
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!sticky) req_valid = req_valid & ~hs_last;
        end
    endtask

    task automatic set_frame(input int k, input logic [FL-1:0] v);
        req_data[k*FL +: FL] = v;
    endtask

    initial begin
        run(3);
        rst = 1'b0;
        run(2);

        // Single request from requester 1.
        gq.delete(); rq.delete(); dr_cnt = 0;
        set_frame(1, 16'hA5F0);
        req_valid = 4'b0010;
        run(25);
        chk("t1_grants", gq.size(), 1);
        if (gq.size() >= 1) chk("t1_gid", gq[0].id, 1);
        chk("t1_results", rq.size(), 1);
        if (rq.size() >= 1) begin
            chk("t1_id", rq[0].id, 1);
            chk("t1_hits", rq[0].hits, 8);
            chk("t1_sat_hits", rq[0].shits, 7);
            chk("t1_latency", rq[0].lat, 19);
        end
        chk("t1_det_rst_cycles", dr_cnt, 1);

        // All four continuously valid after a reset.
        rst = 1'b1; run(1); rst = 1'b0; run(1);
        gq.delete(); rq.delete();
        set_frame(0, 16'h0001); set_frame(1, 16'h0303);
        set_frame(2, 16'h7777); set_frame(3, 16'hFFFF);
        sticky = 1'b1;
        req_valid = 4'b1111;
        run(85);
        sticky = 1'b0;
        req_valid = '0;
        run(25);
        chk("t2_grants", gq.size(), 5);
        if (gq.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t2_gid", gq[i].id, i % 4);
            for (int i = 1; i < 5; i++) chk("t2_spacing", gq[i].cyc - gq[i-1].cyc, 20);
        end
        if (rq.size() >= 4) begin
            chk("t2_id3", rq[3].id, 3);
            chk("t2_hits3", rq[3].hits, 16);
            chk("t2_sat_hits3", rq[3].shits, 7);
            chk("t2_hits2", rq[2].hits, 12);
        end else begin
            chk("t2_results", rq.size(), 5);
        end

        // Requester 2 alone, then 0 and 3 together.
        gq.delete(); rq.delete();
        set_frame(2, 16'h0F0F); set_frame(0, 16'h1234); set_frame(3, 16'h8001);
        req_valid = 4'b0100;
        run(5);
        req_valid = req_valid | 4'b1001;
        run(70);
        chk("t3_grants", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("t3_g0", gq[0].id, 2);
            chk("t3_g1", gq[1].id, 3);
            chk("t3_g2", gq[2].id, 0);
        end

        // Consumer stalls seven cycles in REPORT while requester 0 waits.
        gq.delete(); rq.delete();
        set_frame(3, 16'h00F3);
        done_ready = 1'b0;
        req_valid = 4'b1000;
        run(1);
        req_valid = req_valid | 4'b0001;
        run(25);
        done_ready = 1'b1;
        run(26);
        if (rq.size() >= 1) begin
            chk("t4_id", rq[0].id, 3);
            chk("t4_hits", rq[0].hits, 6);
            chk("t4_held", rq[0].held, 7);
            chk("t4_latency", rq[0].lat, 26);
        end else begin
            chk("t4_results", rq.size(), 2);
        end
        if (gq.size() == 2) begin
            chk("t4_g1", gq[1].id, 0);
            chk("t4_gap", gq[1].cyc - gq[0].cyc, 27);
        end else begin
            chk("t4_grants", gq.size(), 2);
        end

        // Reset in FEED at bit index 5.
        gq.delete(); rq.delete();
        set_frame(2, 16'h0F0F); set_frame(1, 16'h8000);
        req_valid = 4'b0100;
        run(1);
        run(6);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_det_rst", det_rst, 1);
        chk("t5_done_valid", done_valid, 0);
        chk("t5_det_i", det_i, 0);
        run(1);
        req_valid = 4'b0011;
        run(50);
        chk("t5_results", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("t5_r0", rq[0].id, 0);
            chk("t5_r1", rq[1].id, 1);
            chk("t5_r1_hits", rq[1].hits, 1);
        end
        if (gq.size() == 3) begin
            chk("t5_g_after_rst", gq[1].id, 0);
        end else begin
            chk("t5_grants", gq.size(), 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
